serial_frame_deserializer: RTL

- Downstream consumer of the serial shift-register chain's `sout` bit stream.
- Frames one bit per clock (no oversampling): start bit, DATA_W data bits LSB-first, optional even-parity bit, stop bit.
- Presents each received word as a parallel word with a valid/ready handshake.
- Flags parity errors, framing errors and overrun.

---
 rtl/serial_frame_deserializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//
// Receives a serial stream with one bit per clock and returns each frame as a
// parallel word. Frame layout: start bit (0), DATA_W data bits LSB-first, an
// optional even-parity bit, and a stop bit (1). The received word sits in a
// one-entry holding register with a valid/ready handshake.
//
// Parameters:
//   DATA_W     data bits per frame (2..32)
//   PARITY_EN  1 = an even-parity bit follows the data, 0 = no parity bit
//
// Ports:
//   clk         system clock, rising-edge sampling
//   rst         asynchronous reset, active-low
//   sin         serial line, idles high
//   ready       consumer takes dout when high together with dout_valid
//   dout        received word, LSB = first data bit
//   dout_valid  dout holds a word the consumer has not yet taken
//   par_err     parity status of the word in dout
//   frame_err   one-cycle pulse after a stop bit sampled as 0
//   overrun     one-cycle pulse after a good word was dropped (holder full)
//   busy        high whenever the receiver is inside a frame
module serial_frame_deserializer #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sr;
  logic              pbit;

  logic              free;
  logic              word_ok;
  logic              load;
  logic              drop;
  logic              stop_bad;

  // Even parity: data plus parity bit must hold an even number of ones.
  function automatic logic parity_err(input logic [DATA_W-1:0] word,
                                      input logic              pb);
    if (PARITY_EN != 0) begin
      return (^word) ^ pb;
    end
    return 1'b0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    free      = 1'b0;
    word_ok   = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    stop_bad  = 1'b0;

    case (state)
      IDLE: begin
        if (!sin) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        state_nxt = STOP;
      end
      STOP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The holder can take a new word if it is empty or being drained this
    // same cycle; otherwise a completed word is lost and flagged.
    free     = !dout_valid || ready;
    word_ok  = (state == STOP) && sin;
    stop_bad = (state == STOP) && !sin;
    load     = word_ok && free;
    drop     = word_ok && !free;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      sr         <= '0;
      pbit       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= drop;

      case (state)
        IDLE: begin
          cnt <= '0;
        end
        DATA: begin
          sr  <= {sin, sr[DATA_W-1:1]};
          cnt <= cnt + 1'b1;
        end
        PARITY: begin
          pbit <= sin;
        end
        default: begin
        end
      endcase

      // A load wins over a plain accept, so a word arriving while the old
      // one is taken keeps dout_valid high without a bubble.
      if (load) begin
        dout       <= sr;
        par_err    <= parity_err(sr, pbit);
        dout_valid <= 1'b1;
      end else if (dout_valid && ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
